// File: rtl/alu_seq_add4.sv
// alu_seq_add4: multi-cycle add/subtract sequencer.
// Captures WIDTH-bit operands, walks them through one external 2-bit
// full-adder slice two bits per clock (carry rippled through a register),
// then offers the WIDTH-bit result on a valid/ready handshake.
// Optional macro ALU_SEQ_FLAGS_EN adds registered zero/neg/ovf outputs.
module alu_seq_add4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carry_in,
  output logic [1:0]       slice_in1,
  output logic [1:0]       slice_in2,
  output logic             slice_cin,
  input  logic [1:0]       slice_sum,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int NSTEP = WIDTH / 2;
  localparam int IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int MSB   = WIDTH - 1;

  // Odd or tiny widths cannot be split into whole 2-bit slices.
  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("alu_seq_add4: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;        // effective B (already inverted for subtract)
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;    // carry rippling between slice steps
  logic              r_cout;
  logic              r_out_valid;
  logic [IDXW-1:0]   r_idx;

  logic [IDXW:0]     w_lsb;      // bit position of the current slice
  logic              w_last;
  logic [WIDTH-1:0]  w_sum_nx;   // sum with the current slice merged in

`ifdef ALU_SEQ_FLAGS_EN
  logic              r_zero;
  logic              r_neg;
  logic              r_ovf;
`endif

  assign w_lsb  = {r_idx, 1'b0};
  assign w_last = (r_idx == IDXW'(NSTEP - 1));

  // Merge the slice result into the running sum; the flags need the full
  // final value on the last step, before it lands in r_sum.
  always_comb begin
    w_sum_nx = r_sum;
    w_sum_nx[w_lsb +: 2] = slice_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)               w_state_nx = S_CALC;
      S_CALC:  if (w_last)                 w_state_nx = S_HOLD;
      S_HOLD:  if (r_out_valid && out_ready) w_state_nx = S_IDLE;
      default:                             w_state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers only (no in_* -> out_* path).
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    slice_in1 = 2'b00;
    slice_in2 = 2'b00;
    slice_cin = 1'b0;
    if (r_state == S_CALC) begin
      slice_in1 = r_a[w_lsb +: 2];
      slice_in2 = r_b[w_lsb +: 2];
      slice_cin = r_carry;
    end
  end

  // Operand capture, slice-by-slice accumulation and result hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in1;
            r_b     <= op_sub ? ~in2 : in2;
            r_carry <= carry_in;
            r_idx   <= '0;
          end
        end
        S_CALC: begin
          r_sum   <= w_sum_nx;
          r_carry <= slice_cout;
          if (w_last) begin
            r_idx       <= '0;
            r_cout      <= slice_cout;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_HOLD: begin
          if (r_out_valid && out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Status flags latched on the final slice step and held through HOLD.
  // Overflow is judged on the effective B so subtract is covered too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == S_CALC) && w_last) begin
      r_zero <= (w_sum_nx == '0);
      r_neg  <= w_sum_nx[MSB];
      r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_sum_nx[MSB] != r_a[MSB]);
    end
  end

  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
`endif

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq_add4.sv
// Bench for alu_seq_add4 (WIDTH=4): behavioural 2-bit slice on the slice_*
// ports, a transaction-level reference model, a per-cycle compare process
// and directed cases with hand-computed results.
module tb_alu_seq_add4;
  localparam int W     = 4;
  localparam int NSTEP = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         carry_in = 1'b0;
  logic [1:0]   slice_in1, slice_in2, slice_sum;
  logic         slice_cin, slice_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero, neg, ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  alu_seq_add4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .in1(in1), .in2(in2), .carry_in(carry_in),
    .slice_in1(slice_in1), .slice_in2(slice_in2), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out)
`ifdef ALU_SEQ_FLAGS_EN
    , .zero(zero), .neg(neg), .ovf(ovf)
`endif
  );

  // Behavioural 2-bit full-adder slice.
  assign {slice_cout, slice_sum} = 3'(slice_in1) + 3'(slice_in2) + 3'(slice_cin);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation is busy for NSTEP cycles of
  // computation, then its result is offered until out_ready is seen.
  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;
  logic         m_cin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_a    <= in1;
        m_b    <= op_sub ? ~in2 : in2;
        m_cin  <= carry_in;
      end
    end else if (m_cnt < NSTEP) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic calc  = m_busy && (m_cnt < NSTEP);
      automatic logic v_exp = m_busy && (m_cnt == NSTEP);
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, v_exp);
      if (calc) begin
        automatic int lsb  = 2 * m_cnt;
        automatic int mask = (1 << lsb) - 1;
        automatic int cexp = ((int'(m_a) & mask) + (int'(m_b) & mask) + int'(m_cin)) >> lsb;
        chk("slice_in1", slice_in1, (int'(m_a) >> lsb) & 3);
        chk("slice_in2", slice_in2, (int'(m_b) >> lsb) & 3);
        chk("slice_cin", slice_cin, cexp);
      end else begin
        chk("slice_idle", {slice_in1, slice_in2, slice_cin}, 0);
      end
      if (v_exp) begin
        automatic int full = int'(m_a) + int'(m_b) + int'(m_cin);
        automatic logic [W-1:0] es = W'(full);
        chk("sum", sum, es);
        chk("carry_out", carry_out, (full >> W) & 1);
`ifdef ALU_SEQ_FLAGS_EN
        chk("zero", zero, es == 0);
        chk("neg", neg, es[W-1]);
        chk("ovf", ovf, (m_a[W-1] == m_b[W-1]) && (es[W-1] != m_a[W-1]));
`endif
      end
    end
  end

  // Present one request while idle; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic ci);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("issue_timeout", n < 50, 1);
    in1 = a; in2 = b; op_sub = sub; carry_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("valid_timeout", n < 20, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("released_valid", out_valid, 0);
    chk("released_ready", in_ready, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry_out", carry_out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 7 + 5: slice carries 0 then 1, result after two edges.
    issue(4'h7, 4'h5, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_cin0", slice_cin, 0);
    chk("add_lat0", out_valid, 0);
    @(negedge clk);
    chk("add_cin1", slice_cin, 1);
    chk("add_lat1", out_valid, 0);
    @(negedge clk);
    chk("add_lat2", out_valid, 1);
    chk("add_sum", sum, 4'hC);
    chk("add_cout", carry_out, 0);
    release_result();

    // F + 1 wraps to zero.
    issue(4'hF, 4'h1, 1'b0, 1'b0);
    wait_valid();
    chk("wrap_sum", sum, 4'h0);
    chk("wrap_cout", carry_out, 1);
`ifdef ALU_SEQ_FLAGS_EN
    chk("wrap_zero", zero, 1);
    chk("wrap_neg", neg, 0);
    chk("wrap_ovf", ovf, 0);
`endif
    release_result();

    // 5 - 3: no borrow.
    issue(4'h5, 4'h3, 1'b1, 1'b1);
    wait_valid();
    chk("sub_sum", sum, 4'h2);
    chk("sub_cout", carry_out, 1);
    release_result();

    // 3 - 5: borrow.
    issue(4'h3, 4'h5, 1'b1, 1'b1);
    wait_valid();
    chk("subb_sum", sum, 4'hE);
    chk("subb_cout", carry_out, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("subb_neg", neg, 1);
`endif
    release_result();

    // Backpressure: 9 + 4 held for 5 cycles while new requests are offered.
    issue(4'h9, 4'h4, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in1 = W'($urandom); in2 = W'($urandom);
      op_sub = 1'($urandom); carry_in = 1'($urandom);
      @(negedge clk);
      chk("bp_sum", sum, 4'hD);
      chk("bp_cout", carry_out, 0);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    @(negedge clk);
    chk("bp_no_capture", in_ready, 1);

    // Asynchronous reset after the first slice step.
    issue(4'hA, 4'h7, 1'b0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", carry_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 1);

    // 7 + 1 overflows signed range.
    issue(4'h7, 4'h1, 1'b0, 1'b0);
    wait_valid();
    chk("ovf_sum", sum, 4'h8);
    chk("ovf_cout", carry_out, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("ovf_flag", ovf, 1);
    chk("ovf_neg", neg, 1);
`endif
    release_result();

    // Random traffic checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in1       = W'($urandom);
      in2       = W'($urandom);
      op_sub    = 1'($urandom);
      carry_in  = 1'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
